// File: rtl/train_balancer_scheduler_if.sv
// Bundle of the station sensor inputs and the limit/handshake outputs of train_balancer_scheduler.
interface train_balancer_scheduler_if #(
  parameter int N_STATIONS = 4,
  parameter int WIDTH      = 32
);
  logic                          start;
  logic [N_STATIONS-1:0]         station_en;
  logic [N_STATIONS*WIDTH-1:0]   units_at_station;
  logic [N_STATIONS*WIDTH-1:0]   train_count;
  logic [N_STATIONS-1:0]         train_stopped;
  logic                          busy;
  logic                          done;
  logic [WIDTH-1:0]              average_pct;
  logic [N_STATIONS*WIDTH-1:0]   trains_limit;

  modport master (
    output start, station_en, units_at_station, train_count, train_stopped,
    input  busy, done, average_pct, trains_limit
  );

  modport slave (
    input  start, station_en, units_at_station, train_count, train_stopped,
    output busy, done, average_pct, trains_limit
  );
endinterface

// File: rtl/train_balancer_scheduler.sv
// Serial multi-station dropoff balancer: snapshot, accumulate fill %, average, then per-station train limits.
// Optional macro TRAIN_BALANCER_HYSTERESIS_EN: a limit is only committed after two equal consecutive evaluations.
module train_balancer_scheduler #(
  parameter int N_STATIONS          = 4,
  parameter int WIDTH               = 32,
  parameter int QUEUE_LENGTH        = 3,
  parameter int MAX_STOREABLE       = 128000,
  parameter int UNITS_IN_TRAIN_LOAD = 8000,
  parameter int PRECISION           = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  train_balancer_scheduler_if.slave bus
);

  localparam int DW    = 2 * WIDTH;
  localparam int IDX_W = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATIONS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_AVG   = 3'd2;
  localparam logic [2:0] S_LIMIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic signed [WIDTH-1:0] M_W    = WIDTH'(MAX_STOREABLE);
  localparam logic signed [WIDTH-1:0] W_W    = WIDTH'(UNITS_IN_TRAIN_LOAD);
  localparam logic signed [WIDTH-1:0] Q_W    = WIDTH'(QUEUE_LENGTH);
  localparam logic signed [DW-1:0]    M_L    = DW'(MAX_STOREABLE);
  localparam logic signed [DW-1:0]    W_L    = DW'(UNITS_IN_TRAIN_LOAD);
  localparam logic signed [DW-1:0]    P_L    = DW'(PRECISION);

  function automatic logic signed [DW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic signed [WIDTH-1:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] avg_q, avg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [N_STATIONS-1:0]   snap_en_q;
  logic [N_STATIONS-1:0]   snap_stop_q;
  logic signed [WIDTH-1:0] snap_u_q    [N_STATIONS];
  logic signed [WIDTH-1:0] snap_c_q    [N_STATIONS];
  logic signed [WIDTH-1:0] acc_a_q     [N_STATIONS];
  logic signed [WIDTH-1:0] pct_act_q   [N_STATIONS];
  logic signed [WIDTH-1:0] lim_q       [N_STATIONS];
`ifdef TRAIN_BALANCER_HYSTERESIS_EN
  logic signed [WIDTH-1:0] pend_q      [N_STATIONS];
`endif

  logic signed [WIDTH-1:0] en_route, a_val, pct_acc, pct_act, avg_calc;
  logic signed [WIDTH-1:0] free_raw, free_v, tf, td, tdc, ideal, send, lim_calc;

  // Shared serial datapath: ACCUM and LIMIT both operate on the station selected by idx_q.
  always_comb begin
    en_route = snap_c_q[idx_q] - (snap_stop_q[idx_q] ? ONE_W : ZERO_W);
    a_val    = WIDTH'(sext(snap_u_q[idx_q]) + sext(en_route) * W_L);
    pct_acc  = WIDTH'((sext(a_val) * P_L) / M_L);
    pct_act  = WIDTH'((sext(snap_u_q[idx_q]) * P_L) / M_L);
    avg_calc = (cnt_q == ZERO_W) ? ZERO_W : (sum_q / cnt_q);
    free_raw = M_W - acc_a_q[idx_q];
    free_v   = (free_raw < ZERO_W) ? ZERO_W : free_raw;
    tf       = free_v / W_W;
    td       = WIDTH'(((sext(avg_q - pct_act_q[idx_q]) * M_L) / P_L) / W_L);
    tdc      = td + ((td == ZERO_W) ? ONE_W : ZERO_W);
    ideal    = (tf < tdc) ? tf : tdc;
    send     = (ideal < Q_W) ? ideal : Q_W;
    // cnt_q==0 means nothing was enabled; the explicit term keeps the forced-zero rule self-evident.
    lim_calc = (snap_en_q[idx_q] && (cnt_q != ZERO_W) && (avg_q >= pct_act_q[idx_q])) ? send : ZERO_W;
  end

  // Sequencer next-state: walks the stations twice and frames the pass with busy/done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          idx_d   = {IDX_W{1'b0}};
          sum_d   = ZERO_W;
          cnt_d   = ZERO_W;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_ACCUM: begin
        if (snap_en_q[idx_q]) begin
          sum_d = sum_q + pct_acc;
          cnt_d = cnt_q + ONE_W;
        end else begin
          sum_d = sum_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = S_AVG;
        end else begin
          idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_AVG: begin
        avg_d   = avg_calc;
        state_d = S_LIMIT;
      end
      S_LIMIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and scalar result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      sum_q   <= ZERO_W;
      cnt_q   <= ZERO_W;
      avg_q   <= ZERO_W;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Per-station storage: input snapshot, accumulation results and committed limits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_en_q   <= {N_STATIONS{1'b0}};
      snap_stop_q <= {N_STATIONS{1'b0}};
      for (int i = 0; i < N_STATIONS; i++) begin
        snap_u_q[i]  <= ZERO_W;
        snap_c_q[i]  <= ZERO_W;
        acc_a_q[i]   <= ZERO_W;
        pct_act_q[i] <= ZERO_W;
        lim_q[i]     <= ZERO_W;
`ifdef TRAIN_BALANCER_HYSTERESIS_EN
        pend_q[i]    <= ZERO_W;
`endif
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            snap_en_q   <= bus.station_en;
            snap_stop_q <= bus.train_stopped;
            for (int i = 0; i < N_STATIONS; i++) begin
              snap_u_q[i] <= bus.units_at_station[i*WIDTH +: WIDTH];
              snap_c_q[i] <= bus.train_count[i*WIDTH +: WIDTH];
            end
          end
        end
        S_ACCUM: begin
          if (snap_en_q[idx_q]) begin
            acc_a_q[idx_q]   <= a_val;
            pct_act_q[idx_q] <= pct_act;
          end
        end
        S_LIMIT: begin
`ifdef TRAIN_BALANCER_HYSTERESIS_EN
          if (!snap_en_q[idx_q]) begin
            lim_q[idx_q]  <= ZERO_W;
            pend_q[idx_q] <= ZERO_W;
          end else if (lim_calc == pend_q[idx_q]) begin
            lim_q[idx_q]  <= lim_calc;
          end else begin
            pend_q[idx_q] <= lim_calc;
          end
`else
          lim_q[idx_q] <= lim_calc;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.average_pct = avg_q;

  for (genvar g = 0; g < N_STATIONS; g++) begin : g_lim_out
    assign bus.trains_limit[g*WIDTH +: WIDTH] = lim_q[g];
  end

endmodule

// File: tb/tb_train_balancer_scheduler.sv
// Scoreboard bench for train_balancer_scheduler (N=2); expected results come from a behavioural model.
module tb_train_balancer_scheduler;
  localparam int N  = 2;
  localparam int WD = 32;
  localparam longint M = 128000;
  localparam longint W = 8000;
  localparam longint Q = 3;
  localparam longint P = 1000;

  typedef struct packed {
    logic [WD-1:0]   avg;
    logic [N*WD-1:0] lim;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  longint         s_u [N];
  longint         s_c [N];
  logic [N-1:0]   s_en;
  logic [N-1:0]   s_stop;
  longint         m_lim [N];
  longint         m_pend [N];
  exp_t           sb_q [$];

  always #5 clk = ~clk;

  train_balancer_scheduler_if #(.N_STATIONS(N), .WIDTH(WD)) bus ();

  train_balancer_scheduler #(
    .N_STATIONS(N), .WIDTH(WD), .QUEUE_LENGTH(3), .MAX_STOREABLE(128000),
    .UNITS_IN_TRAIN_LOAD(8000), .PRECISION(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic set_scn(input longint u0, input longint u1, input longint c0, input longint c1,
                         input logic [1:0] stop, input logic [1:0] en);
    s_u[0] = u0; s_u[1] = u1; s_c[0] = c0; s_c[1] = c1;
    s_stop = stop; s_en = en;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.units_at_station[i*WD +: WD] = s_u[i][WD-1:0];
      bus.train_count[i*WD +: WD]      = s_c[i][WD-1:0];
    end
    bus.station_en    = s_en;
    bus.train_stopped = s_stop;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lim[i] = 0;
      m_pend[i] = 0;
    end
    sb_q.delete();
  endtask

  task automatic model_push();
    longint a [N];
    longint pa [N];
    longint sum, cnt, avg, fr, tf, td, tdc, idl, snd, lim;
    exp_t   e;
    sum = 0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      a[i] = 0; pa[i] = 0;
      if (s_en[i]) begin
        a[i]  = s_u[i] + (s_c[i] - longint'(s_stop[i])) * W;
        sum  += (a[i] * P) / M;
        cnt  += 1;
        pa[i] = (s_u[i] * P) / M;
      end
    end
    avg = (cnt == 0) ? 0 : sum / cnt;
    e.avg = avg[WD-1:0];
    for (int i = 0; i < N; i++) begin
      fr  = M - a[i];
      if (fr < 0) fr = 0;
      tf  = fr / W;
      td  = ((avg - pa[i]) * M / P) / W;
      tdc = (td == 0) ? 1 : td;
      idl = (tf < tdc) ? tf : tdc;
      snd = (idl < Q) ? idl : Q;
      lim = (s_en[i] && avg >= pa[i]) ? snd : 0;
`ifdef TRAIN_BALANCER_HYSTERESIS_EN
      if (!s_en[i]) begin
        m_lim[i] = 0; m_pend[i] = 0;
      end else if (lim == m_pend[i]) begin
        m_lim[i] = lim;
      end else begin
        m_pend[i] = lim;
      end
`else
      m_lim[i] = lim;
`endif
      e.lim[i*WD +: WD] = m_lim[i][WD-1:0];
    end
    sb_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One evaluation: checks busy, per-station write timing, done latency and the scoreboard result.
  task automatic run_eval(input bit pulse_mid);
    exp_t h;
    bit   got;
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk);
    model_push();
    @(negedge clk);
    bus.start = 1'b0;
    bus.units_at_station = {$urandom, $urandom};
    bus.train_count      = {$urandom, $urandom};
    bus.station_en       = ~s_en;
    bus.train_stopped    = ~s_stop;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_accept: got %0b expected 1", bus.busy);
    end
    got = 1'b0;
    for (int e = 1; e <= 4*N + 8 && !got; e++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = (pulse_mid && e == 2) ? 1'b1 : 1'b0;
      h = sb_q[0];
      for (int i = 0; i < N; i++) begin
        if (e == N + 2 + i) begin
          tests_run++;
          if (bus.trains_limit[i*WD +: WD] !== h.lim[i*WD +: WD]) begin
            tests_failed++;
            $display("FAIL limit_write_time[%0d]: got %0d expected %0d at edge %0d", i,
                     bus.trains_limit[i*WD +: WD], h.lim[i*WD +: WD], e);
          end
        end
      end
      if (bus.done === 1'b1) begin
        got = 1'b1;
        tests_run++;
        if (e != 2*N + 1 || bus.busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL done_timing: got edge %0d busy %0b expected edge %0d busy 0", e, bus.busy, 2*N + 1);
        end
        tests_run++;
        if (bus.average_pct !== h.avg) begin
          tests_failed++;
          $display("FAIL average_pct: got %0d expected %0d", $signed(bus.average_pct), $signed(h.avg));
        end
        tests_run++;
        if (bus.trains_limit !== h.lim) begin
          tests_failed++;
          $display("FAIL trains_limit: got {%0d,%0d} expected {%0d,%0d}",
                   bus.trains_limit[WD-1:0], bus.trains_limit[2*WD-1:WD], h.lim[WD-1:0], h.lim[2*WD-1:WD]);
        end
        void'(sb_q.pop_front());
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: got no done expected done within %0d edges", 4*N + 8);
      sb_q.delete();
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_after_done: got done %0b busy %0b expected 0 0", bus.done, bus.busy);
      end
    end
  endtask

  task automatic check_lims(input string name, input longint l0, input longint l1);
    tests_run++;
    if (bus.trains_limit[WD-1:0] !== l0[WD-1:0] || bus.trains_limit[2*WD-1:WD] !== l1[WD-1:0]) begin
      tests_failed++;
      $display("FAIL %s: got {%0d,%0d} expected {%0d,%0d}", name,
               bus.trains_limit[WD-1:0], bus.trains_limit[2*WD-1:WD], l0, l1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_scn(0, 0, 0, 0, 2'b00, 2'b00);
    drive_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.average_pct !== 32'd0 || bus.trains_limit !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy %0b done %0b avg %0d lim %0h expected all 0",
               bus.busy, bus.done, bus.average_pct, bus.trains_limit);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_scn(0, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b0);
    tests_run++;
    if (bus.average_pct !== 32'd250) begin
      tests_failed++;
      $display("FAIL basic_avg_const: got %0d expected 250", bus.average_pct);
    end
`ifndef TRAIN_BALANCER_HYSTERESIS_EN
    check_lims("basic_lims_const", 3, 0);
`endif
  endtask

  task automatic test_td_clip();
    set_scn(60000, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b0);
    tests_run++;
    if (bus.average_pct !== 32'd484) begin
      tests_failed++;
      $display("FAIL td_clip_avg_const: got %0d expected 484", bus.average_pct);
    end
  endtask

  task automatic test_en_route();
    set_scn(0, 0, 2, 0, 2'b01, 2'b11);
    run_eval(1'b0);
    tests_run++;
    if (bus.average_pct !== 32'd31) begin
      tests_failed++;
      $display("FAIL en_route_avg_const: got %0d expected 31", bus.average_pct);
    end
  endtask

  task automatic test_partial_enable();
    set_scn(0, 999999, 0, 0, 2'b00, 2'b01);
    run_eval(1'b0);
    set_scn(0, 999999, 0, 0, 2'b00, 2'b00);
    run_eval(1'b0);
`ifndef TRAIN_BALANCER_HYSTERESIS_EN
    check_lims("none_enabled_const", 0, 0);
`endif
  endtask

  task automatic test_busy_ignore();
    set_scn(0, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b1);
  endtask

  task automatic test_reset_mid();
    set_scn(0, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b0);
    @(negedge clk);
    drive_inputs();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (N + 2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.average_pct !== 32'd0 || bus.trains_limit !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_limit: got busy %0b done %0b avg %0d lim %0h expected all 0",
               bus.busy, bus.done, bus.average_pct, bus.trains_limit);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_eval(1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      set_scn($urandom_range(0, 200000), $urandom_range(0, 200000), $urandom_range(0, 4),
              $urandom_range(0, 4), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      run_eval(1'b0);
    end
  endtask

`ifdef TRAIN_BALANCER_HYSTERESIS_EN
  task automatic test_hysteresis();
    apply_reset();
    set_scn(0, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b0);
    check_lims("hyst_s1_first", 0, 0);
    run_eval(1'b0);
    check_lims("hyst_s1_second", 3, 0);
    set_scn(60000, 64000, 0, 0, 2'b00, 2'b11);
    run_eval(1'b0);
    check_lims("hyst_s2_first", 3, 0);
    run_eval(1'b0);
    check_lims("hyst_s2_second", 1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_td_clip();
    test_en_route();
    test_partial_enable();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef TRAIN_BALANCER_HYSTERESIS_EN
    test_hysteresis();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
